// File: rtl/bm_pos_interlock_mc_if.sv
// Bus bundle for bm_pos_interlock_mc: BPM sample stream, envelope/vote configuration and interlock status.
interface bm_pos_interlock_mc_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10,
  parameter int unsigned CW = 16
);
  logic                 frame_trig;
  logic                 valid;
  logic signed [DW-1:0] x;
  logic signed [DW-1:0] y;
  logic [AW-1:0]        addr;
  logic                 mask;
  logic signed [DW-1:0] x_hi;
  logic signed [DW-1:0] x_lo;
  logic signed [DW-1:0] y_hi;
  logic signed [DW-1:0] y_lo;
  logic [AW-1:0]        vote_thr;
  logic                 clear_latch;

  logic                 il_sum;
  logic [AW-1:0]        frame_err_cnt;
  logic                 trip;
  logic [AW-1:0]        first_addr;
  logic [3:0]           first_cause;
  logic [CW-1:0]        x_env_cnt;
  logic [CW-1:0]        y_env_cnt;
  logic                 overrun;

  modport master (
    output frame_trig, valid, x, y, addr, mask, x_hi, x_lo, y_hi, y_lo, vote_thr, clear_latch,
    input  il_sum, frame_err_cnt, trip, first_addr, first_cause, x_env_cnt, y_env_cnt, overrun
  );

  modport slave (
    input  frame_trig, valid, x, y, addr, mask, x_hi, x_lo, y_hi, y_lo, vote_thr, clear_latch,
    output il_sum, frame_err_cnt, trip, first_addr, first_cause, x_env_cnt, y_env_cnt, overrun
  );
endinterface

// File: rtl/bm_pos_interlock_mc.sv
// BPM position interlock: per-sample envelope check, per-frame fault voting and latched beam-dump request.
// Optional macro BM_ZERO_DETECT_EN: treat a y reading of exactly zero as a fault (cause 4'b1111).
module bm_pos_interlock_mc #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10,
  parameter int unsigned CW = 16
) (
  input logic                  clk,
  input logic                  reset,
  bm_pos_interlock_mc_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, EVAL, TRIPPED} state_t;

  localparam logic [AW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] ENV_MAX = '1;

  state_t        r_state;
  logic          r_valid_q;
  logic          r_seen;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] r_shadow_addr;
  logic [3:0]    r_shadow_cause;
  logic          r_il_sum;
  logic          r_trip;
  logic          r_overrun;
  logic [AW-1:0] r_frame_err_cnt;
  logic [AW-1:0] r_first_addr;
  logic [3:0]    r_first_cause;
  logic [CW-1:0] r_x_env;
  logic [CW-1:0] r_y_env;

  logic signed [DW-1:0] w_x;
  logic signed [DW-1:0] w_y;
  logic       w_qual;
  logic [3:0] w_cause;
  logic       w_fault;
  logic       w_x_out;
  logic       w_y_out;
  logic       w_fall;
  logic       w_hit;

  assign w_x = bus.x;
  assign w_y = bus.y;

  // Sample classification; envelope counters use the open interval, the interlock uses inclusive limits.
  always_comb begin
    w_qual  = bus.valid & bus.mask;
    w_cause = {(w_y <= bus.y_lo), (w_y >= bus.y_hi), (w_x <= bus.x_lo), (w_x >= bus.x_hi)};
    w_fault = w_qual & (|w_cause);
`ifdef BM_ZERO_DETECT_EN
    if (w_y == '0) begin
      w_cause = 4'b1111;
      w_fault = w_qual;
    end
`endif
    w_x_out = w_qual & ((w_x > bus.x_hi) | (w_x < bus.x_lo));
    w_y_out = w_qual & ((w_y > bus.y_hi) | (w_y < bus.y_lo));
    w_fall  = r_valid_q & ~bus.valid;
    w_hit   = (bus.vote_thr != '0) & (r_cnt >= bus.vote_thr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= IDLE;
      r_valid_q       <= 1'b0;
      r_seen          <= 1'b0;
      r_cnt           <= '0;
      r_shadow_addr   <= '0;
      r_shadow_cause  <= '0;
      r_il_sum        <= 1'b0;
      r_trip          <= 1'b0;
      r_overrun       <= 1'b0;
      r_frame_err_cnt <= '0;
      r_first_addr    <= '0;
      r_first_cause   <= '0;
      r_x_env         <= '0;
      r_y_env         <= '0;
    end else begin
      r_il_sum  <= w_fault;
      r_valid_q <= bus.valid;
      if (w_x_out && (r_x_env != ENV_MAX)) r_x_env <= r_x_env + CW'(1);
      if (w_y_out && (r_y_env != ENV_MAX)) r_y_env <= r_y_env + CW'(1);

      if (bus.clear_latch) begin
        // Clear wins over a trip decided this cycle, but the frame count still lands.
        r_trip        <= 1'b0;
        r_first_addr  <= '0;
        r_first_cause <= '0;
        r_state       <= IDLE;
        if (r_state == EVAL) r_frame_err_cnt <= r_cnt;
      end else begin
        case (r_state)
          IDLE, TRIPPED: begin
            if (bus.frame_trig) begin
              r_state <= ACCUM;
              r_cnt   <= '0;
              r_seen  <= 1'b0;
            end
          end
          ACCUM: begin
            if (bus.frame_trig) begin
              r_overrun <= 1'b1;
              r_cnt     <= '0;
              r_seen    <= 1'b0;
            end else begin
              if (w_fault) begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + AW'(1);
                if (!r_seen) begin
                  r_seen         <= 1'b1;
                  r_shadow_addr  <= bus.addr;
                  r_shadow_cause <= w_cause;
                end
              end
              if (w_fall) r_state <= EVAL;
            end
          end
          EVAL: begin
            r_frame_err_cnt <= r_cnt;
            if (w_hit && !r_trip) begin
              r_trip        <= 1'b1;
              r_first_addr  <= r_shadow_addr;
              r_first_cause <= r_shadow_cause;
            end
            // Once latched, frames keep cycling through TRIPPED until cleared.
            if (bus.frame_trig) begin
              r_state <= ACCUM;
              r_cnt   <= '0;
              r_seen  <= 1'b0;
            end else if (w_hit || r_trip) begin
              r_state <= TRIPPED;
            end else begin
              r_state <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.il_sum        = r_il_sum;
  assign bus.frame_err_cnt = r_frame_err_cnt;
  assign bus.trip          = r_trip;
  assign bus.first_addr    = r_first_addr;
  assign bus.first_cause   = r_first_cause;
  assign bus.x_env_cnt     = r_x_env;
  assign bus.y_env_cnt     = r_y_env;
  assign bus.overrun       = r_overrun;
endmodule

// File: tb/tb_bm_pos_interlock_mc.sv
// Bench for bm_pos_interlock_mc: random BPM frames against a frame-level reference model and a timed scoreboard.
module tb_bm_pos_interlock_mc;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned CW = 16;
  localparam int N   = 360;
  localparam int LIM = 1000;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  chk_t q[$];
  chk_t it;

  bit m_trip, m_overrun;
  int m_err, m_fa, m_fc, m_xenv, m_yenv, m_thr;
  int sx[N], sy[N], sa[N];
  bit sm[N];

  bm_pos_interlock_mc_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();
  bm_pos_interlock_mc #(.DW(DW), .AW(AW), .CW(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit m_fault(bit v, bit mk, int xv, int yv);
    bit f = v && mk && (xv >= LIM || xv <= -LIM || yv >= LIM || yv <= -LIM);
`ifdef BM_ZERO_DETECT_EN
    if (v && mk && yv == 0) f = 1'b1;
`endif
    return f;
  endfunction

  function automatic int m_cause(int xv, int yv);
`ifdef BM_ZERO_DETECT_EN
    if (yv == 0) return 15;
`endif
    return (yv <= -LIM ? 8 : 0) + (yv >= LIM ? 4 : 0) + (xv <= -LIM ? 2 : 0) + (xv >= LIM ? 1 : 0);
  endfunction

  function automatic logic [31:0] get_act(int sel);
    case (sel)
      0: return 32'(bus.il_sum);
      1: return 32'(bus.frame_err_cnt);
      2: return 32'(bus.trip);
      3: return 32'(bus.first_addr);
      4: return 32'(bus.first_cause);
      5: return 32'(bus.x_env_cnt);
      6: return 32'(bus.y_env_cnt);
      7: return 32'(bus.overrun);
      default: return 32'hdead;
    endcase
  endfunction

  function automatic string sel_name(int sel);
    case (sel)
      0: return "il_sum";
      1: return "frame_err_cnt";
      2: return "trip";
      3: return "first_addr";
      4: return "first_cause";
      5: return "x_env_cnt";
      6: return "y_env_cnt";
      7: return "overrun";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: compare every expectation whose due cycle has arrived.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      it = q.pop_front();
      n_checks++;
      if (get_act(it.sel) !== it.exp) begin
        n_fail++;
        $display("FAIL %s at cycle %0d: got %0d, expected %0d", sel_name(it.sel), cyc, get_act(it.sel), it.exp);
      end
    end
  end

  task automatic expect_at(int d, int sel, int exp);
    chk_t c;
    c.due = cyc + d;
    c.sel = sel;
    c.exp = 32'(exp);
    q.push_back(c);
  endtask

  task automatic check_all(int d);
    expect_at(d, 1, m_err);
    expect_at(d, 2, int'(m_trip));
    expect_at(d, 3, m_fa);
    expect_at(d, 4, m_fc);
    expect_at(d, 5, m_xenv);
    expect_at(d, 6, m_yenv);
    expect_at(d, 7, int'(m_overrun));
  endtask

  task automatic model_zero();
    m_trip = 0; m_overrun = 0; m_err = 0; m_fa = 0; m_fc = 0; m_xenv = 0; m_yenv = 0;
  endtask

  task automatic drive_cycle(bit trig, bit v, int xv, int yv, int av, bit mk, bit clr);
    @(posedge clk); #1;
    bus.frame_trig  = trig;
    bus.valid       = v;
    bus.x           = xv;
    bus.y           = yv;
    bus.addr        = AW'(av);
    bus.mask        = mk;
    bus.clear_latch = clr;
    expect_at(1, 0, int'(m_fault(v, mk, xv, yv)));
    if (v && mk && (xv > LIM || xv < -LIM) && m_xenv < 65535) m_xenv++;
    if (v && mk && (yv > LIM || yv < -LIM) && m_yenv < 65535) m_yenv++;
  endtask

  task automatic idle();
    drive_cycle(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_thr(int t);
    m_thr = t;
    bus.vote_thr = AW'(t);
  endtask

  task automatic gen_clean();
    for (int i = 0; i < N; i++) begin
      sx[i] = int'($urandom_range(1998)) - 999;
      sy[i] = int'($urandom_range(998)) + 1;
      if ($urandom_range(1) != 0) sy[i] = -sy[i];
      sa[i] = i;
      sm[i] = 1'b1;
    end
  endtask

  task automatic inject_random(int k);
    int idx;
    for (int j = 0; j < k; j++) begin
      idx = int'($urandom_range(N - 1));
      case ($urandom_range(7))
        0: sx[idx] = LIM;
        1: sx[idx] = -LIM;
        2: sy[idx] = LIM;
        3: sy[idx] = -LIM;
        4: sx[idx] = LIM + 1 + int'($urandom_range(5000));
        5: sy[idx] = -LIM - 1;
        6: begin sx[idx] = 3000; sm[idx] = 1'b0; end
        default: sx[idx] = LIM - 1;
      endcase
    end
  endtask

  // One frame: trigger, N samples, valid drop; frame result expected two cycles after the drop.
  task automatic run_frame(int trig_at);
    int cnt = 0;
    bit seen = 0;
    int fa = 0;
    int fc = 0;
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) begin
      drive_cycle(i == trig_at, 1, sx[i], sy[i], sa[i], sm[i], 0);
      if (i == trig_at) begin
        m_overrun = 1;
        cnt = 0;
        seen = 0;
        expect_at(2, 1, m_err);
        expect_at(2, 7, 1);
      end else if (m_fault(1, sm[i], sx[i], sy[i])) begin
        if (cnt < 1023) cnt++;
        if (!seen) begin
          seen = 1;
          fa = sa[i];
          fc = m_cause(sx[i], sy[i]);
        end
      end
    end
    idle();
    m_err = cnt;
    if (m_thr != 0 && cnt >= m_thr && !m_trip) begin
      m_trip = 1;
      m_fa = fa;
      m_fc = fc;
    end
    check_all(2);
    idle();
    idle();
  endtask

  task automatic do_clear();
    drive_cycle(0, 0, 0, 0, 0, 0, 1);
    m_trip = 0;
    m_fa = 0;
    m_fc = 0;
    check_all(1);
    idle();
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    q.delete();
    reset = 1'b1;
    bus.frame_trig = 0; bus.valid = 0; bus.mask = 0; bus.clear_latch = 0;
    model_zero();
    expect_at(0, 0, 0);
    check_all(0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    bus.frame_trig = 0; bus.valid = 0; bus.x = 0; bus.y = 0; bus.addr = '0;
    bus.mask = 0; bus.clear_latch = 0;
    bus.x_hi = LIM; bus.x_lo = -LIM; bus.y_hi = LIM; bus.y_lo = -LIM;
    set_thr(4);
    model_zero();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    expect_at(0, 0, 0);
    check_all(0);

    // Three faults at x == upper limit: counted, below vote threshold.
    gen_clean();
    for (int j = 0; j < 3; j++) sx[j * 100 + int'($urandom_range(99))] = LIM;
    run_frame(-1);

    // Faulty samples outside a frame flag il_sum and envelopes but do not vote.
    for (int j = 0; j < 3; j++) drive_cycle(0, 1, 5000, 10, 7, 1, 0);
    idle();
    idle();
    check_all(1);

    // Four faults, first one at addr 17 on the y low limit: trips.
    gen_clean();
    sy[17] = -LIM;
    for (int j = 1; j < 4; j++) sx[j * 100 + int'($urandom_range(59))] = LIM;
    run_frame(-1);

    // Clean frame while tripped, then clear, then clean frame from IDLE.
    gen_clean();
    run_frame(-1);
    do_clear();
    gen_clean();
    run_frame(-1);

    // Randomised frames with random threshold and fault mix.
    for (int r = 0; r < 6; r++) begin
      set_thr(int'($urandom_range(5)));
      gen_clean();
      inject_random(int'($urandom_range(6)));
      run_frame(-1);
      if (m_trip && $urandom_range(1) != 0) do_clear();
    end
    if (m_trip) do_clear();

    // Overrun: re-trigger at sample 200.
    set_thr(4);
    gen_clean();
    sx[30] = LIM;
    sx[60] = LIM;
    run_frame(-1);
    gen_clean();
    sx[50] = LIM; sx[200] = LIM; sx[250] = LIM; sx[300] = LIM; sx[310] = LIM;
    run_frame(200);

    // y == 0 at addr 3, four times.
    gen_clean();
    for (int j = 0; j < 4; j++) begin
      sy[50 + 10 * j] = 0;
      sa[50 + 10 * j] = 3;
    end
    run_frame(-1);
    if (m_trip) do_clear();

    // Reset in the middle of a frame with five faults counted.
    gen_clean();
    for (int j = 0; j < 5; j++) sx[j] = LIM;
    drive_cycle(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive_cycle(0, 1, sx[i], sy[i], sa[i], sm[i], 0);
    do_reset();
    gen_clean();
    sx[100] = LIM;
    sy[200] = LIM;
    run_frame(-1);

    for (int w = 0; w < 20 && q.size() > 0; w++) @(negedge clk);
    while (q.size() > 0) begin
      it = q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation never reached its due cycle %0d", sel_name(it.sel), it.due);
    end

    // Settled end-of-test state against the reference model.
    n_checks++;
    if (32'(bus.frame_err_cnt) !== 32'(m_err)) begin
      n_fail++;
      $display("FAIL final frame_err_cnt: got %0d, expected %0d", bus.frame_err_cnt, m_err);
    end
    n_checks++;
    if (bus.trip !== m_trip) begin
      n_fail++;
      $display("FAIL final trip: got %0d, expected %0d", bus.trip, m_trip);
    end
    n_checks++;
    if (bus.overrun !== m_overrun) begin
      n_fail++;
      $display("FAIL final overrun: got %0d, expected %0d", bus.overrun, m_overrun);
    end
    n_checks++;
    if (32'(bus.x_env_cnt) !== 32'(m_xenv)) begin
      n_fail++;
      $display("FAIL final x_env_cnt: got %0d, expected %0d", bus.x_env_cnt, m_xenv);
    end
    n_checks++;
    if (32'(bus.y_env_cnt) !== 32'(m_yenv)) begin
      n_fail++;
      $display("FAIL final y_env_cnt: got %0d, expected %0d", bus.y_env_cnt, m_yenv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bm_pos_interlock_mc.md
BM_POS_INTERLOCK_MC -- requirements
Module: bm_pos_interlock_mc

Interface
- REQ-001 SHALL have parameter DW, default 32: signed position/limit width.
- REQ-002 SHALL have parameter AW, default 10: BPM address width.
- REQ-003 SHALL have parameter CW, default 16: error/envelope counter width.
- REQ-004 SHALL have ports clk (in, 1, clock) and reset (in, 1, asynchronous, active-high).
- REQ-005 SHALL have port frame_trig (in, 1): start-of-frame pulse, 10 kHz.
- REQ-006 SHALL have port valid (in, 1): one sample per cycle while high within a frame.
- REQ-007 SHALL have ports x, y (in, DW each, signed): BPM position sample.
- REQ-008 SHALL have port addr (in, AW): BPM index of the current sample.
- REQ-009 SHALL have port mask (in, 1): sample is enabled for interlock.
- REQ-010 SHALL have ports x_hi, x_lo, y_hi, y_lo (in, DW each, signed): envelope limits.
- REQ-011 SHALL have port vote_thr (in, AW): trip threshold, number of faulted BPMs per frame.
- REQ-012 SHALL have port clear_latch (in, 1): clears the trip latch.
- REQ-013 SHALL have port il_sum (out, 1): registered per-sample fault.
- REQ-014 SHALL have port frame_err_cnt (out, AW): faults in the last completed frame.
- REQ-015 SHALL have port trip (out, 1): latched beam-dump request.
- REQ-016 SHALL have ports first_addr (out, AW) and first_cause (out, 4, {y_lo,y_hi,x_lo,x_hi}): first fault of the tripping frame.
- REQ-017 SHALL have ports x_env_cnt, y_env_cnt (out, CW each): lifetime out-of-envelope counts.
- REQ-018 SHALL have port overrun (out, 1): sticky flag, frame_trig arrived before the frame was evaluated.

Function
- REQ-019 Per-sample fault SHALL be valid & mask & (x>=x_hi | x<=x_lo | y>=y_hi | y<=y_lo), using signed compare.
- REQ-020 il_sum SHALL equal the fault term delayed by exactly 1 cycle.
- REQ-021 FSM SHALL have the states IDLE, ACCUM, EVAL and TRIPPED.
- REQ-022 On frame_trig, the FSM SHALL go from IDLE to ACCUM and clear the running count the next cycle.
- REQ-023 In ACCUM, each fault SHALL increment the running count, saturating at 2^AW-1.
- REQ-024 The first fault in a frame SHALL capture addr and cause into the shadow registers.
- REQ-025 On the falling edge of valid in ACCUM, the FSM SHALL go to EVAL.
- REQ-026 EVAL SHALL last 1 cycle and copy the running count to frame_err_cnt.
- REQ-027 From EVAL, the FSM SHALL go to TRIPPED if count>=vote_thr and vote_thr!=0, else to IDLE.
- REQ-028 On entry to TRIPPED, first_addr and first_cause SHALL load from the shadow registers and trip SHALL set; trip is sticky.
- REQ-029 In TRIPPED, frame_trig SHALL still run frames (TRIPPED->ACCUM->EVAL->TRIPPED), updating frame_err_cnt but not first_*.
- REQ-030 clear_latch SHALL clear trip, first_addr and first_cause and force IDLE; it has priority over simultaneous EVAL trip.
- REQ-031 frame_trig in ACCUM SHALL set overrun, discard the running frame and restart ACCUM; frame_err_cnt is unchanged.
- REQ-032 frame_trig in EVAL SHALL complete the evaluation, then enter ACCUM.
- REQ-033 Samples outside ACCUM SHALL drive il_sum but SHALL NOT count toward voting.
- REQ-034 x_env_cnt SHALL increment when valid & mask & x outside [x_lo,x_hi]; y_env_cnt likewise uses y only. Both saturate and ignore frames.

Reset
- REQ-035 Reset SHALL force IDLE and clear all outputs, counters, shadow registers and overrun to 0.
- REQ-036 Reset mid-frame SHALL discard the frame; the first frame_trig after deassertion starts normally.

Configuration
- REQ-037 BM_ZERO_DETECT_EN defined: valid & mask & y==0 SHALL also count as a fault, with first_cause=4'b1111.
- REQ-038 BM_ZERO_DETECT_EN undefined: y==0 SHALL be treated as an ordinary position.

Verification
- REQ-039 Limits ±1000, vote_thr=4, 360 samples with 3 at x=1000 -> frame_err_cnt=3, trip=0.
- REQ-040 Same frame with 4 faults, first at addr 17 with y=-1000 -> trip=1, first_addr=17, first_cause=4'b1000.
- REQ-041 After trip, a clean frame then clear_latch -> frame_err_cnt=0, trip stays 1 until clear_latch, then 0 and IDLE.
- REQ-042 frame_trig at sample 200 of 360 -> overrun=1, previous frame_err_cnt retained, new frame counts from 0.
- REQ-043 Reset asserted mid-ACCUM with 5 faults counted -> all outputs 0; next frame evaluates independently.
- REQ-044 BM_ZERO_DETECT_EN, mask=1, y=0 at addr 3 x4, vote_thr=4 -> trip=1, first_cause=4'b1111; without the macro -> trip=0.
